// File: rtl/lfsr_rx.sv
// Framed LFSR stream decryptor: length byte, payload, XOR checksum, 9-bit keystream.
// Define LFSR_RX_TIMEOUT_EN to abort frames after TIMEOUT_CYCLES idle cycles.
module lfsr_rx #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] key,
    input  logic [2:0] tap,
    input  logic [7:0] in_byte,
    input  logic       in_en,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] out_byte,
    output logic       out_en,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_ok,
    output logic       frame_err
);

    // state  | meaning
    // S_IDLE | waiting for start; input bytes ignored
    // S_LEN  | expecting the length byte
    // S_DATA | expecting payload bytes, count_q still to come
    // S_SUM  | expecting the checksum byte
    typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_SUM} state_t;

    state_t     state_q;
    logic [8:0] lfsr_q;
    logic [7:0] count_q;
    logic [7:0] sum_q;
    logic [7:0] out_byte_q;
    logic       out_en_q;
    logic       busy_q;
    logic       frame_done_q;
    logic       frame_ok_q;
    logic       frame_err_q;

    logic [8:0] lfsr_d;
    logic [7:0] plain;
    logic       timeout_hit;
    logic       abort;

    assign plain  = in_byte ^ lfsr_q[7:0];
    assign lfsr_d = {lfsr_q[7:0], lfsr_q[tap] ^ lfsr_q[8]};
    assign abort  = stop | timeout_hit;

`ifdef LFSR_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_q;

    // Down-counter reloads on activity; terminal count 1 on an idle cycle aborts.
    assign timeout_hit = busy_q && !in_en && (idle_q == TW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q <= '0;
        end else if ((state_q == S_IDLE && start) || (busy_q && in_en)) begin
            idle_q <= TW'(TIMEOUT_CYCLES);
        end else if (busy_q && idle_q != '0) begin
            idle_q <= idle_q - TW'(1);
        end
    end
`else
    // Without the timer a frame waits indefinitely; the parameter is inert.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lfsr_q       <= '0;
            count_q      <= '0;
            sum_q        <= '0;
            out_byte_q   <= '0;
            out_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            out_en_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (state_q == S_IDLE) begin
                if (start) begin
                    lfsr_q     <= {1'b0, key};
                    sum_q      <= '0;
                    frame_ok_q <= 1'b0;
                    busy_q     <= 1'b1;
                    state_q    <= S_LEN;
                end
            end else if (abort) begin
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
                frame_err_q <= 1'b1;
            end else if (in_en) begin
                lfsr_q <= lfsr_d;
                case (state_q)
                    S_LEN: begin
                        count_q <= plain;
                        state_q <= (plain == 8'd0) ? S_SUM : S_DATA;
                    end
                    S_DATA: begin
                        out_byte_q <= plain;
                        out_en_q   <= 1'b1;
                        sum_q      <= sum_q ^ plain;
                        count_q    <= count_q - 8'd1;
                        if (count_q == 8'd1) state_q <= S_SUM;
                    end
                    S_SUM: begin
                        frame_done_q <= 1'b1;
                        frame_ok_q   <= (plain == sum_q);
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign out_byte   = out_byte_q;
    assign out_en     = out_en_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign frame_err  = frame_err_q;

endmodule
